// File: rtl/mux5_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : mux5_pkg
//  Brief    : Shared constants, state type and select encoding for the
//             five-source round-robin mux scheduler.
//  Revision : 1.0  initial release
// ============================================================================
package mux5_pkg;

    localparam int N_SRC = 5;

    localparam logic [2:0] SRC_U = 3'd0;
    localparam logic [2:0] SRC_V = 3'd1;
    localparam logic [2:0] SRC_W = 3'd2;
    localparam logic [2:0] SRC_X = 3'd3;
    localparam logic [2:0] SRC_Y = 3'd4;

    localparam logic [2:0] SEL_U = 3'b000;
    localparam logic [2:0] SEL_V = 3'b001;
    localparam logic [2:0] SEL_W = 3'b010;
    localparam logic [2:0] SEL_X = 3'b011;
    localparam logic [2:0] SEL_Y = 3'b100;

    typedef enum logic [0:0] {
        IDLE  = 1'b0,
        GRANT = 1'b1
    } state_t;

    // Out-of-range indices fold onto U so 101..111 can never reach the mux.
    function automatic logic [2:0] idx2sel(input logic [2:0] idx);
        logic [2:0] sel;
        case (idx)
            SRC_U:   sel = SEL_U;
            SRC_V:   sel = SEL_V;
            SRC_W:   sel = SEL_W;
            SRC_X:   sel = SEL_X;
            SRC_Y:   sel = SEL_Y;
            default: sel = SEL_U;
        endcase
        return sel;
    endfunction

endpackage
`default_nettype wire

// File: rtl/mux5_rr_sched_if.sv
`default_nettype none
// ============================================================================
//  Module   : mux5_rr_sched_if
//  Brief    : Request/data/grant bundle between the five sources and the
//             round-robin scheduler.
//  Revision : 1.0  initial release
// ============================================================================
interface mux5_rr_sched_if #(
    parameter int DATA_WIDTH = 3
);
    logic [4:0]              req;
    logic [5*DATA_WIDTH-1:0] din;
    logic [4:0]              gnt;
    logic                    s2;
    logic                    s1;
    logic                    s0;
    logic [DATA_WIDTH-1:0]   m_data;
    logic                    m_valid;
    logic [2:0]              m_src;

    modport master (
        output req, din,
        input  gnt, s2, s1, s0, m_data, m_valid, m_src
    );

    modport slave (
        input  req, din,
        output gnt, s2, s1, s0, m_data, m_valid, m_src
    );
endinterface
`default_nettype wire

// File: rtl/mux5_sel.sv
`default_nettype none
// ============================================================================
//  Module   : mux5_sel
//  Brief    : Combinational 5:1 word mux steered by s2/s1/s0.
//  Revision : 1.0  initial release
// ============================================================================
module mux5_sel
    import mux5_pkg::*;
#(
    parameter int DATA_WIDTH = 3
) (
    input  wire logic [5*DATA_WIDTH-1:0] i_din,
    input  wire logic                    i_s2,
    input  wire logic                    i_s1,
    input  wire logic                    i_s0,
    output logic      [DATA_WIDTH-1:0]   o_data
);

    always_comb begin
        o_data = '0;
        case ({i_s2, i_s1, i_s0})
            SEL_U:   o_data = i_din[0*DATA_WIDTH +: DATA_WIDTH];
            SEL_V:   o_data = i_din[1*DATA_WIDTH +: DATA_WIDTH];
            SEL_W:   o_data = i_din[2*DATA_WIDTH +: DATA_WIDTH];
            SEL_X:   o_data = i_din[3*DATA_WIDTH +: DATA_WIDTH];
            SEL_Y:   o_data = i_din[4*DATA_WIDTH +: DATA_WIDTH];
            default: o_data = '0;
        endcase
    end

endmodule
`default_nettype wire

// File: rtl/mux5_rr_sched.sv
`default_nettype none
// ============================================================================
//  Module   : mux5_rr_sched
//  Brief    : Round-robin burst scheduler driving a shared 5:1 mux and
//             registering the selected word with a valid flag.
//  Revision : 1.0  initial release
// ============================================================================
module mux5_rr_sched
    import mux5_pkg::*;
#(
    parameter int DATA_WIDTH = 3,
    parameter int MAX_HOLD   = 4
) (
    input  wire logic     clk,
    input  wire logic     rst_n,
    mux5_rr_sched_if.slave bus
);

    localparam int         HCW       = $clog2(MAX_HOLD + 1);
    localparam logic [HCW-1:0] c_HOLD_MAX = HCW'(MAX_HOLD);
    localparam logic [HCW-1:0] c_HOLD_ONE = HCW'(1);

    state_t                r_state;
    logic [2:0]            r_owner;
    logic [2:0]            r_last;
    logic [HCW-1:0]        r_hold;
    logic [4:0]            r_gnt;
    logic [2:0]            r_sel;
    logic [DATA_WIDTH-1:0] r_m_data;
    logic                  r_m_valid;
    logic [2:0]            r_m_src;

    state_t                w_state_nxt;
    logic [2:0]            w_owner_nxt;
    logic [2:0]            w_last_nxt;
    logic [HCW-1:0]        w_hold_nxt;
    logic [4:0]            w_gnt_nxt;
    logic [2:0]            w_sel_nxt;
    logic                  w_own_req;
    logic [4:0]            w_others;
    logic [DATA_WIDTH-1:0] w_mux_data;

    // First set bit scanning last+1, last+2, ... modulo five.
    function automatic logic [2:0] rr_pick(input logic [4:0] r, input logic [2:0] last);
        logic [2:0] pick;
        int         c;
        pick = last;
        for (int k = N_SRC - 1; k >= 0; k--) begin
            c = (int'(last) + 1 + k) % N_SRC;
            if (r[c]) pick = 3'(c);
        end
        return pick;
    endfunction

    function automatic logic [4:0] idx2onehot(input logic [2:0] idx);
        return 5'b00001 << idx;
    endfunction

    // r_gnt is the owner's one-hot whenever a grant is active.
    assign w_own_req = |(bus.req & r_gnt);
    assign w_others  = bus.req & ~r_gnt;

    mux5_sel #(
        .DATA_WIDTH (DATA_WIDTH)
    ) u_sel (
        .i_din  (bus.din),
        .i_s2   (r_sel[2]),
        .i_s1   (r_sel[1]),
        .i_s0   (r_sel[0]),
        .o_data (w_mux_data)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state   <= IDLE;
            r_owner   <= SRC_U;
            r_last    <= SRC_Y;
            r_hold    <= '0;
            r_gnt     <= '0;
            r_sel     <= SEL_U;
            r_m_data  <= '0;
            r_m_valid <= 1'b0;
            r_m_src   <= SRC_U;
        end else begin
            r_state   <= w_state_nxt;
            r_owner   <= w_owner_nxt;
            r_last    <= w_last_nxt;
            r_hold    <= w_hold_nxt;
            r_gnt     <= w_gnt_nxt;
            r_sel     <= w_sel_nxt;
            r_m_valid <= (r_state == GRANT) && w_own_req;
            if ((r_state == GRANT) && w_own_req) begin
                r_m_data <= w_mux_data;
                r_m_src  <= r_owner;
            end
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_owner_nxt = r_owner;
        w_last_nxt  = r_last;
        w_hold_nxt  = r_hold;
        case (r_state)
            IDLE: begin
                if (|bus.req) begin
                    w_state_nxt = GRANT;
                    w_owner_nxt = rr_pick(bus.req, r_last);
                    w_last_nxt  = w_owner_nxt;
                    w_hold_nxt  = c_HOLD_ONE;
                end
            end
            GRANT: begin
                if (w_own_req && (r_hold < c_HOLD_MAX)) begin
                    w_hold_nxt = r_hold + c_HOLD_ONE;
                end else if (|w_others) begin
                    w_owner_nxt = rr_pick(w_others, r_last);
                    w_last_nxt  = w_owner_nxt;
                    w_hold_nxt  = c_HOLD_ONE;
                end else if (w_own_req) begin
                    w_hold_nxt = c_HOLD_ONE;
                end else begin
                    w_state_nxt = IDLE;
                    w_hold_nxt  = '0;
                end
            end
            default: begin
                w_state_nxt = IDLE;
                w_hold_nxt  = '0;
            end
        endcase
    end

    // Select holds its last value while idle.
    always_comb begin
        w_gnt_nxt = '0;
        w_sel_nxt = r_sel;
        if (w_state_nxt == GRANT) begin
            w_gnt_nxt = idx2onehot(w_owner_nxt);
            w_sel_nxt = idx2sel(w_owner_nxt);
        end
    end

    assign bus.gnt     = r_gnt;
    assign bus.s2      = r_sel[2];
    assign bus.s1      = r_sel[1];
    assign bus.s0      = r_sel[0];
    assign bus.m_data  = r_m_data;
    assign bus.m_valid = r_m_valid;
    assign bus.m_src   = r_m_src;

endmodule
`default_nettype wire
